// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: state encoding, opcode constants, IR field positions and
// decode helpers shared by the alu_step_sequencer control-step generator.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_DONE, ST_ILL
  } state_t;

  typedef enum logic [1:0] {
    CLS_BINARY, CLS_UNARY, CLS_WIDE, CLS_ILLEGAL
  } op_class_t;

  // Field widths and offsets counted down from the IR MSB
  localparam int OP_W   = 5;
  localparam int REG_W  = 4;
  localparam int RA_OFS = 5;
  localparam int RB_OFS = 9;
  localparam int RC_OFS = 13;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR = 5'b00111;
  localparam logic [OP_W-1:0] OP_SHL = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROR = 5'b01001;
  localparam logic [OP_W-1:0] OP_ROL = 5'b01010;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV = 5'b01111;
  localparam logic [OP_W-1:0] OP_NEG = 5'b10000;
  localparam logic [OP_W-1:0] OP_NOT = 5'b10001;

  // Single-bit datapath controls plus the ALU operation, registered as one word
  typedef struct packed {
    logic pc_out;
    logic mdr_out;
    logic zhigh_out;
    logic zlow_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic inc_pc;
    logic read;
    logic zhigh_in;
    logic zlow_in;
    logic hi_in;
    logic lo_in;
    logic busy;
    logic done;
    logic illegal;
    logic [OP_W-1:0] alu_op;
  } ctrl_t;

  function automatic op_class_t op_class(input logic [OP_W-1:0] opcode);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: cls = CLS_BINARY;
      OP_NEG, OP_NOT:                 cls = CLS_UNARY;
      OP_MUL, OP_DIV:                 cls = CLS_WIDE;
      default:                        cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic logic reg_ok(input logic [REG_W-1:0] idx, input int num_regs);
    return int'(idx) < num_regs;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// reg_onehot_dec: register index to one-hot select with enable; indices at or
// beyond NUM_REGS produce an all-zero vector.
module reg_onehot_dec #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic                en,
  input  logic [IDX_W-1:0]    idx,
  output logic [NUM_REGS-1:0] onehot
);

  // Set the single bit that matches the index when enabled
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == IDX_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_step_sequencer.sv
// alu_step_sequencer: clocked T0..T6 control-step generator for Mini SRC
// register-to-register ALU instructions. Outputs are Moore, registered from
// the next state. Clear is an asynchronous active-low reset.
// Optional feature: define ALU_SEQ_WIDE_EN to enable the MUL/DIV wide path
// (T6, ZHighIn, LOin, HIin); otherwise MUL/DIV decode as illegal.
module alu_step_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int MEM_LAT  = 1
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Start,
  input  logic [DATA_W-1:0]   IR,
  output logic                PCout,
  output logic                MDRout,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                MARin,
  output logic                PCin,
  output logic                MDRin,
  output logic                IRin,
  output logic                Yin,
  output logic                IncPC,
  output logic                Read,
  output logic                ZHighIn,
  output logic                ZLowIn,
  output logic                HIin,
  output logic                LOin,
  output logic [4:0]          ALUop,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                Busy,
  output logic                Done,
  output logic                Illegal
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt, next_cnt;
  logic [OP_W-1:0]     ir_op, op_q, sel_op;
  logic [REG_W-1:0]    ir_ra, ir_rb, ir_rc;
  logic [REG_W-1:0]    ra_q, rb_q, rc_q;
  logic [REG_W-1:0]    sel_ra, sel_rb, sel_rc;
  op_class_t           sel_class;
  ctrl_t               ctrl_d, ctrl_q;
  logic                rin_en, rout_en;
  logic [REG_W-1:0]    rin_idx, rout_idx;
  logic [NUM_REGS-1:0] rin_d, rout_d, rin_q, rout_q;
  logic                unused_ir_low;

  assign ir_op = IR[DATA_W-1 -: OP_W];
  assign ir_ra = IR[DATA_W-1-RA_OFS -: REG_W];
  assign ir_rb = IR[DATA_W-1-RB_OFS -: REG_W];
  assign ir_rc = IR[DATA_W-1-RC_OFS -: REG_W];
  assign unused_ir_low = ^IR[DATA_W-1-RC_OFS-REG_W:0];

  // While leaving T2 the live IR is decoded (it is latched on that same edge);
  // from T3 onward only the latched copy is used, so later IR changes are ignored.
  assign sel_op = (state == ST_T2) ? ir_op : op_q;
  assign sel_ra = (state == ST_T2) ? ir_ra : ra_q;
  assign sel_rb = (state == ST_T2) ? ir_rb : rb_q;
  assign sel_rc = (state == ST_T2) ? ir_rc : rc_q;

  // Classify the selected instruction, folding in register-range and build options
  always_comb begin
    sel_class = op_class(sel_op);
`ifdef ALU_SEQ_WIDE_EN
`else
    if (sel_class == CLS_WIDE) sel_class = CLS_ILLEGAL;
`endif
    if (!reg_ok(sel_ra, NUM_REGS) || !reg_ok(sel_rb, NUM_REGS) || !reg_ok(sel_rc, NUM_REGS))
      sel_class = CLS_ILLEGAL;
  end

  // Next-state and memory-wait counter
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      ST_IDLE: if (Start) next_state = ST_T0;
      ST_T0: begin
        next_state = ST_T1;
        next_cnt   = CNT_LOAD;
      end
      ST_T1: begin
        if (cnt == '0) next_state = ST_T2;
        else           next_cnt   = cnt - 1'b1;
      end
      ST_T2: next_state = ST_T3;
      ST_T3: begin
        case (sel_class)
          CLS_ILLEGAL: next_state = ST_ILL;
          CLS_UNARY:   next_state = ST_T5;
          default:     next_state = ST_T4;
        endcase
      end
      ST_T4: next_state = ST_T5;
`ifdef ALU_SEQ_WIDE_EN
      ST_T5: next_state = (sel_class == CLS_WIDE) ? ST_T6 : ST_DONE;
      ST_T6: next_state = ST_DONE;
`else
      ST_T5: next_state = ST_DONE;
`endif
      ST_DONE: next_state = ST_IDLE;
      ST_ILL:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Control word for the upcoming state; Busy also covers the ILL terminal cycle
  always_comb begin
    ctrl_d      = '0;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rin_idx     = sel_ra;
    rout_idx    = sel_rb;
    ctrl_d.busy = (next_state != ST_IDLE);
    case (next_state)
      ST_T0: begin
        ctrl_d.pc_out = 1'b1;
        ctrl_d.mar_in = 1'b1;
        ctrl_d.inc_pc = 1'b1;
        ctrl_d.pc_in  = 1'b1;
      end
      ST_T1: begin
        ctrl_d.read   = 1'b1;
        ctrl_d.mdr_in = 1'b1;
      end
      ST_T2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      ST_T3: begin
        if (sel_class != CLS_ILLEGAL) begin
          rout_en = 1'b1;
          if (sel_class == CLS_UNARY) begin
            ctrl_d.alu_op  = sel_op;
            ctrl_d.zlow_in = 1'b1;
          end else begin
            ctrl_d.y_in = 1'b1;
          end
        end
      end
      ST_T4: begin
        rout_en        = 1'b1;
        rout_idx       = sel_rc;
        ctrl_d.alu_op  = sel_op;
        ctrl_d.zlow_in = 1'b1;
`ifdef ALU_SEQ_WIDE_EN
        if (sel_class == CLS_WIDE) ctrl_d.zhigh_in = 1'b1;
`endif
      end
      ST_T5: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.alu_op   = sel_op;
`ifdef ALU_SEQ_WIDE_EN
        if (sel_class == CLS_WIDE) ctrl_d.lo_in = 1'b1;
        else                       rin_en       = 1'b1;
`else
        rin_en = 1'b1;
`endif
      end
`ifdef ALU_SEQ_WIDE_EN
      ST_T6: begin
        ctrl_d.zhigh_out = 1'b1;
        ctrl_d.hi_in     = 1'b1;
      end
`endif
      ST_DONE: ctrl_d.done    = 1'b1;
      ST_ILL:  ctrl_d.illegal = 1'b1;
      default: ;
    endcase
  end

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_W)) u_rin_dec (
    .en     (rin_en),
    .idx    (rin_idx),
    .onehot (rin_d)
  );

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_W)) u_rout_dec (
    .en     (rout_en),
    .idx    (rout_idx),
    .onehot (rout_d)
  );

  // State register and memory-wait counter
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Capture opcode and register fields as the sequencer enters T3
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
    end else if (state == ST_T2) begin
      op_q <= ir_op;
      ra_q <= ir_ra;
      rb_q <= ir_rb;
      rc_q <= ir_rc;
    end
  end

  // Registered outputs so every control changes only on the rising clock
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      ctrl_q <= '0;
      rin_q  <= '0;
      rout_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rin_q  <= rin_d;
      rout_q <= rout_d;
    end
  end

  assign PCout    = ctrl_q.pc_out;
  assign MDRout   = ctrl_q.mdr_out;
  assign Zhighout = ctrl_q.zhigh_out;
  assign Zlowout  = ctrl_q.zlow_out;
  assign MARin    = ctrl_q.mar_in;
  assign PCin     = ctrl_q.pc_in;
  assign MDRin    = ctrl_q.mdr_in;
  assign IRin     = ctrl_q.ir_in;
  assign Yin      = ctrl_q.y_in;
  assign IncPC    = ctrl_q.inc_pc;
  assign Read     = ctrl_q.read;
  assign ZHighIn  = ctrl_q.zhigh_in;
  assign ZLowIn   = ctrl_q.zlow_in;
  assign HIin     = ctrl_q.hi_in;
  assign LOin     = ctrl_q.lo_in;
  assign ALUop    = ctrl_q.alu_op;
  assign Busy     = ctrl_q.busy;
  assign Done     = ctrl_q.done;
  assign Illegal  = ctrl_q.illegal;
  assign Rin      = rin_q;
  assign Rout     = rout_q;

endmodule
